// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order word requests
// to instruction memory and buffers returned words in a FIFO toward decode.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_valid,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [31:0]   last_pc_reg, last_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] word_mem [DEPTH];

  logic [CW:0]  credit_used;
  logic         accept;
  logic         rsp;
  logic         drop;
  logic         push;
  logic         pop;
  logic [31:0]  redirect_base;

  // Credit covers both buffered words and in-flight requests (stale ones
  // included), so a returning word always finds a free FIFO slot.
  assign credit_used   = {1'b0, outstanding_reg} + {1'b0, count_reg};
  assign imem_valid    = (credit_used < DEPTH_W);
  assign imem_addr     = fetch_pc_reg;

  assign accept        = imem_valid & imem_ready;
  assign rsp           = imem_rvalid & (outstanding_reg != '0);
  assign drop          = rsp & (redirect | (discard_reg != '0));
  assign push          = rsp & ~drop;
  assign pop           = instr_valid & instr_ready & ~redirect;
  assign redirect_base = redirect_pc & 32'hFFFF_FFFC;

  assign instr_valid   = (count_reg != '0);
  assign instr         = instr_valid ? word_mem[rd_ptr_reg] : NOP;
  assign instr_pc      = instr_valid ? pc_mem[rd_ptr_reg] : last_pc_reg;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    last_pc_next     = last_pc_reg;
    count_next       = count_reg;
    outstanding_next = outstanding_reg + CW'(accept) - CW'(rsp);
    discard_next     = discard_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;

    if (redirect) begin
      // Everything still in flight, including this cycle's accept, is stale.
      fetch_pc_next = redirect_base;
      rsp_pc_next   = redirect_base;
      count_next    = '0;
      discard_next  = outstanding_next;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
    end else begin
      if (accept) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (drop) begin
        discard_next = discard_reg - CW'(1);
      end
      if (push) begin
        rsp_pc_next = rsp_pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        last_pc_next = pc_mem[rd_ptr_reg];
        rd_ptr_next  = rd_ptr_reg + PW'(1);
      end
      count_next = count_reg + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      last_pc_reg     <= '0;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      last_pc_reg     <= last_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
      word_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: a latency-configurable in-order memory model
// feeds the DUT while scenario tasks check outputs against hand-derived values.
module tb_fetch_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_valid;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] acc_q[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_word[$];

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Accept/pop logging at the active edge; memory answers in order at the falling edge.
  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
    end else begin
      if (imem_valid && imem_ready) begin
        mq.push_back('{imem_addr, cyc + lat});
        acc_q.push_back(imem_addr);
        $display("req  addr=%h", imem_addr);
      end
      if (!redirect && instr_valid && instr_ready) begin
        pop_pc.push_back(instr_pc);
        pop_word.push_back(instr);
        $display("pop  pc=%h instr=%h", instr_pc, instr);
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid <= 1'b1;
      imem_rdata  <= mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_logs();
    acc_q.delete();
    pop_pc.delete();
    pop_word.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ready = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    tick(); tick();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL reset_imem_valid: got %b expected 1", imem_valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_imem_addr: got %h expected 00000100", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; imem_ready = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL stream_empty_nop: got %h expected 00000013", instr); end
    repeat (11) tick();
    checks++; if (acc_q.size() !== 12) begin errors++; $display("FAIL stream_accepts: got %0d expected 12", acc_q.size()); end
    checks++; if (pop_pc.size() !== 10) begin errors++; $display("FAIL stream_pops: got %0d expected 10", pop_pc.size()); end
    for (int i = 0; i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, acc_q[i], 32'h100 + 32'(4 * i)); end
    end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'h100 + 32'(4 * i)); end
      checks++; if (pop_word[i] !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL stream_word[%0d]: got %h expected %h", i, pop_word[i], mem_word(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1; imem_ready = 1'b1; instr_ready = 1'b0;
    repeat (10) tick();
    checks++; if (acc_q.size() !== 4) begin errors++; $display("FAIL stall_accepts: got %0d expected 4", acc_q.size()); end
    checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL stall_imem_valid: got %b expected 0", imem_valid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_instr_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL stall_head_pc: got %h expected 00000100", instr_pc); end
    checks++; if (pop_pc.size() !== 0) begin errors++; $display("FAIL stall_no_pop: got %0d expected 0", pop_pc.size()); end
    instr_ready = 1'b1;
    repeat (10) tick();
    checks++; if (pop_pc.size() !== 10) begin errors++; $display("FAIL stall_release_pops: got %0d expected 10", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'h100 + 32'(4 * i)); end
      checks++; if (pop_word[i] !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("FAIL stall_word[%0d]: got %h expected %h", i, pop_word[i], mem_word(32'h100 + 32'(4 * i))); end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3; imem_ready = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'h2000) begin errors++; $display("FAIL redir_addr: got %h expected 00002000", imem_addr); end
    checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL redir_imem_valid: got %b expected 1", imem_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_instr_valid: got %b expected 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_drop[%0d]: got %b expected 0", i, instr_valid); end
    end
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h2000) begin errors++; $display("FAIL redir_first_pc: got %h expected 00002000", instr_pc); end
    checks++; if (instr !== mem_word(32'h2000)) begin errors++; $display("FAIL redir_first_instr: got %h expected %h", instr, mem_word(32'h2000)); end
    repeat (4) tick();
    if (acc_q.size() < 4) begin
      errors++; $display("FAIL redir_acc_count: got %0d expected at least 4", acc_q.size());
    end else begin
      checks++; if (acc_q[3] !== 32'h2000) begin errors++; $display("FAIL redir_acc3: got %h expected 00002000", acc_q[3]); end
    end
    checks++; if (pop_pc.size() !== 4) begin errors++; $display("FAIL redir_pops: got %0d expected 4", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'h2000 + 32'(4 * i)) begin errors++; $display("FAIL redir_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'h2000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    do_reset();
    lat = 1; imem_ready = 1'b1; instr_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_rvalid !== 1'b1) begin errors++; $display("FAIL rvp_setup_rvalid: got %b expected 1", imem_rvalid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rvp_setup_valid: got %b expected 1", instr_valid); end
    redirect = 1'b1; redirect_pc = 32'h0000_3000;
    tick();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rvp_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rvp_instr: got %h expected 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rvp_instr_pc: got %h expected 00000000", instr_pc); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL rvp_addr: got %h expected 00003000", imem_addr); end
    checks++; if (pop_pc.size() !== 0) begin errors++; $display("FAIL rvp_no_pop: got %0d expected 0", pop_pc.size()); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rvp_discard_one: got %b expected 0", instr_valid); end
    tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rvp_new_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h3000) begin errors++; $display("FAIL rvp_new_pc: got %h expected 00003000", instr_pc); end
    checks++; if (instr !== mem_word(32'h3000)) begin errors++; $display("FAIL rvp_new_instr: got %h expected %h", instr, mem_word(32'h3000)); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_acc [4];
    logic [31:0] exp_pop [3];
    exp_acc = '{32'h0000_0100, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    exp_pop = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    lat = 1; imem_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_redir_addr: got %h expected fffffff8", imem_addr); end
    repeat (6) tick();
    if (acc_q.size() < 4 || pop_pc.size() < 3) begin
      errors++; $display("FAIL wrap_counts: got %0d/%0d expected at least 4/3", acc_q.size(), pop_pc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (acc_q[i] !== exp_acc[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, acc_q[i], exp_acc[i]); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (pop_pc[i] !== exp_pop[i]) begin errors++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, pop_pc[i], exp_pop[i]); end
        checks++; if (pop_word[i] !== mem_word(exp_pop[i])) begin errors++; $display("FAIL wrap_word[%0d]: got %h expected %h", i, pop_word[i], mem_word(exp_pop[i])); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 1; imem_ready = 1'b1; instr_ready = 1'b0;
    repeat (4) tick();
    checks++; if (instr_pc !== 32'h100) begin errors++; $display("FAIL mid_setup_head: got %h expected 00000100", instr_pc); end
    reset = 1'b1;
    tick();
    checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL mid_imem_valid: got %b expected 1", imem_valid); end
    checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mid_imem_addr: got %h expected 00000100", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL mid_instr: got %h expected 00000013", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL mid_instr_pc: got %h expected 00000000", instr_pc); end
    reset = 1'b0;
    clear_logs();
    instr_ready = 1'b1;
    repeat (4) tick();
    checks++; if (pop_pc.size() !== 2) begin errors++; $display("FAIL mid_restart_pops: got %0d expected 2", pop_pc.size()); end
    for (int i = 0; i < pop_pc.size(); i++) begin
      checks++; if (pop_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL mid_restart_pc[%0d]: got %h expected %h", i, pop_pc[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_rvalid_pop();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
